// File: rtl/ramp_scan_ctrl_pkg.sv
// Shared definitions for the ramp scan / lock acquisition controller.
//   RDefault  : default width of the ramp and error datapath
//   state_e   : controller state encoding (visible on the state output)
//   eff_scans : number of ramp periods to search, with 0 treated as 1
package ramp_scan_ctrl_pkg;

  localparam int unsigned RDefault = 14;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRrst = 3'd1,
    StArm  = 3'd2,
    StScan = 3'd3,
    StSeek = 3'd4,
    StLock = 3'd5,
    StErr  = 3'd6
  } state_e;

  function automatic logic [7:0] eff_scans(input logic [7:0] n);
    return (n == 8'd0) ? 8'd1 : n;
  endfunction

endpackage

// File: rtl/peak_tracker.sv
// Extremum tracker: remembers the best sig sample and the pos at which it was seen.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : unconditionally capture sig/pos (start of a search)
//   track      : capture sig/pos only if sig strictly beats the stored value
//   search_max : 1 = keep the maximum, 0 = keep the minimum
//   sig, pos   : sample and its ramp position
//   peak_val, peak_pos : stored extremum and its position
// With load and track both low the tracker is frozen.
module peak_tracker
  import ramp_scan_ctrl_pkg::*;
#(
  parameter int unsigned R = RDefault
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                track,
  input  logic                search_max,
  input  logic signed [R-1:0] sig,
  input  logic signed [R-1:0] pos,
  output logic signed [R-1:0] peak_val,
  output logic signed [R-1:0] peak_pos
);

  logic signed [R-1:0] val_q;
  logic signed [R-1:0] pos_q;
  logic                better;

  // Strict comparison so that ties keep the earliest position.
  always_comb begin
    better = search_max ? (sig > val_q) : (sig < val_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
      pos_q <= '0;
    end else if (load || (track && better)) begin
      val_q <= sig;
      pos_q <= pos;
    end
  end

  assign peak_val = val_q;
  assign peak_pos = pos_q;

endmodule

// File: rtl/ramp_scan_ctrl.sv
// Ramp scan controller: sweeps the ramp for n_scans periods, finds the extremum of
// sig_in, drives the ramp back to that position and hands over to the lock loops.
//   clk, rst                 : clock, asynchronous active-high reset
//   start, abort             : start on rising edge; abort (level) returns to idle
//   n_scans, timeout         : periods to search; ARM/SEEK cycle limit (0 = none)
//   search_max               : 1 = search maximum, 0 = search minimum
//   ramp_A, trigger_low/hig  : ramp value and limit pulses from the ramp generator
//   sig_in                   : signal to be searched
//   ramp_enable, ramp_reset  : ramp generator controls
//   peak_val, peak_pos       : found extremum and its ramp position
//   lock_en, busy, done, error, state : handover and status
module ramp_scan_ctrl
  import ramp_scan_ctrl_pkg::*;
#(
  parameter int unsigned R = RDefault
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [7:0]          n_scans,
  input  logic [31:0]         timeout,
  input  logic                search_max,
  input  logic signed [R-1:0] ramp_A,
  input  logic                trigger_low,
  input  logic                trigger_hig,
  input  logic signed [R-1:0] sig_in,
  output logic                ramp_enable,
  output logic                ramp_reset,
  output logic signed [R-1:0] peak_val,
  output logic signed [R-1:0] peak_pos,
  output logic                lock_en,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [2:0]          state
);

  state_e      state_q, state_d;
  logic        start_q;
  logic [7:0]  n_scans_q;
  logic [31:0] timeout_q;
  logic        search_max_q;
  logic [31:0] tmr_q, tmr_d;
  logic [7:0]  per_q, per_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        load, track;
  logic        start_edge, timed_out;
  logic [31:0] tmr_inc;
  logic        unused_trigger_hig;

  assign unused_trigger_hig = trigger_hig;

  assign start_edge = start & ~start_q;
  assign tmr_inc    = tmr_q + 32'd1;
  // The timer counts cycles already spent in ARM/SEEK, so the state lasts
  // exactly timeout cycles before ERR.
  assign timed_out  = (timeout_q != 32'd0) && (tmr_inc == timeout_q);

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    per_d       = per_q;
    done_d      = done_q;
    error_d     = error_q;
    ramp_enable = 1'b0;
    ramp_reset  = 1'b0;
    lock_en     = 1'b0;
    busy        = 1'b0;
    load        = 1'b0;
    track       = 1'b0;

    unique case (state_q)
      StIdle: if (start_edge) state_d = StRrst;
      StRrst: begin
        ramp_reset = 1'b1;
        busy       = 1'b1;
        tmr_d      = '0;
        state_d    = StArm;
      end
      StArm: begin
        ramp_enable = 1'b1;
        busy        = 1'b1;
        tmr_d       = tmr_inc;
        if (trigger_low) begin
          load    = 1'b1;
          per_d   = '0;
          state_d = StScan;
        end else if (timed_out) begin
          state_d = StErr;
        end
      end
      StScan: begin
        ramp_enable = 1'b1;
        busy        = 1'b1;
        track       = 1'b1;  // still captures on the final trigger cycle
        if (trigger_low) begin
          per_d = per_q + 8'd1;
          if (per_d >= eff_scans(n_scans_q)) begin
            tmr_d   = '0;
            state_d = StSeek;
          end
        end
      end
      StSeek: begin
        busy = 1'b1;
        if (ramp_A == peak_pos) begin
          state_d = StLock;  // ramp_enable stays low this very cycle
        end else begin
          ramp_enable = 1'b1;
          tmr_d       = tmr_inc;
          if (timed_out) state_d = StErr;
        end
      end
      StLock: begin
        lock_en = 1'b1;
        if (start_edge) state_d = StRrst;
      end
      StErr: if (start_edge) state_d = StRrst;
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      load    = 1'b0;
      track   = 1'b0;
    end

    if (state_d == StRrst) begin
      done_d  = 1'b0;
      error_d = 1'b0;
    end
    if (state_d == StLock) done_d = 1'b1;
    if (state_d == StErr) error_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      start_q      <= 1'b0;
      n_scans_q    <= '0;
      timeout_q    <= '0;
      search_max_q <= 1'b0;
      tmr_q        <= '0;
      per_q        <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      tmr_q   <= tmr_d;
      per_q   <= per_d;
      done_q  <= done_d;
      error_q <= error_d;
      if (state_q == StRrst) begin
        n_scans_q    <= n_scans;
        timeout_q    <= timeout;
        search_max_q <= search_max;
      end
    end
  end

  peak_tracker #(
    .R(R)
  ) u_peak_tracker (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .track     (track),
    .search_max(search_max_q),
    .sig       (sig_in),
    .pos       (ramp_A),
    .peak_val  (peak_val),
    .peak_pos  (peak_pos)
  );

  assign state = state_q;
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_ramp_scan_ctrl.sv
module tb_ramp_scan_ctrl;

  localparam int R    = 14;
  localparam int LO   = -100;
  localparam int HI   = 200;
  localparam int STEP = 10;
  localparam int SIDLE = 0, SRRST = 1, SARM = 2, SSCAN = 3, SSEEK = 4, SLOCK = 5, SERR = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [7:0] n_scans = 8'd1;
  logic [31:0] timeout = 32'd0;
  logic search_max = 1'b1;
  logic signed [R-1:0] ramp_A;
  logic trigger_low = 1'b0;
  logic trigger_hig = 1'b0;
  logic signed [R-1:0] sig_in;
  logic ramp_enable, ramp_reset, lock_en, busy, done, error;
  logic signed [R-1:0] peak_val, peak_pos;
  logic [2:0] state;

  ramp_scan_ctrl #(.R(R)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .n_scans(n_scans),
    .timeout(timeout), .search_max(search_max), .ramp_A(ramp_A),
    .trigger_low(trigger_low), .trigger_hig(trigger_hig), .sig_in(sig_in),
    .ramp_enable(ramp_enable), .ramp_reset(ramp_reset), .peak_val(peak_val),
    .peak_pos(peak_pos), .lock_en(lock_en), .busy(busy), .done(done),
    .error(error), .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- ramp generator and signal source ----------------
  int  ramp_i = LO;
  int  mode = 0;
  bit  no_trig = 1'b0;
  bit  en_s = 1'b0, rs_s = 1'b0;

  always @(negedge clk) begin
    en_s = ramp_enable;
    rs_s = ramp_reset;
  end

  always @(posedge clk) begin
    #1;
    trigger_low = 1'b0;
    trigger_hig = 1'b0;
    if (rs_s) begin
      ramp_i = LO;
      trigger_low = !no_trig;
    end else if (en_s) begin
      if (ramp_i >= HI) begin
        ramp_i = LO;
        trigger_low = !no_trig;
      end else begin
        ramp_i = ramp_i + STEP;
        trigger_hig = (ramp_i == HI);
      end
    end
  end

  always @* begin
    int v;
    ramp_A = R'(ramp_i);
    if (mode == 0) v = (ramp_i == 120) ? 500 : ramp_i;
    else v = (ramp_i == -50 || ramp_i == 80) ? -300 : 0;
    sig_in = R'(v);
  end

  // ---------------- behavioural model ----------------
  int     m_state = SIDLE;
  int     m_nsh = 0, m_per = 0;
  longint m_tsh = 0, m_tcnt = 0;
  bit     m_msh = 1'b0, m_qmax = 1'b0, m_done = 1'b0, m_err = 1'b0, m_sp = 1'b0, m_edge;
  int     qs[$], qp[$];  // samples seen by the current/last search

  function automatic void best(output int v, output int p);
    v = 0;
    p = 0;
    if (qs.size() == 0) return;
    v = qs[0];
    p = qp[0];
    for (int i = 1; i < qs.size(); i++)
      if (m_qmax ? (qs[i] > v) : (qs[i] < v)) begin
        v = qs[i];
        p = qp[i];
      end
  endfunction

  always @(posedge clk or posedge rst) begin
    int bv, bp;
    if (rst) begin
      m_state = SIDLE; m_nsh = 0; m_tsh = 0; m_tcnt = 0; m_per = 0;
      m_msh = 0; m_qmax = 0; m_done = 0; m_err = 0; m_sp = 0;
      qs.delete(); qp.delete();
    end else begin
      m_edge = start && !m_sp;
      m_sp = start;
      if (abort) m_state = SIDLE;
      else if (m_state == SIDLE || m_state == SLOCK || m_state == SERR) begin
        if (m_edge) begin
          m_state = SRRST; m_done = 0; m_err = 0;
        end
      end else if (m_state == SRRST) begin
        m_nsh = n_scans; m_tsh = timeout; m_msh = search_max; m_tcnt = 0; m_state = SARM;
      end else if (m_state == SARM) begin
        if (trigger_low) begin
          qs.delete(); qp.delete();
          qs.push_back(int'(sig_in)); qp.push_back(int'(ramp_A));
          m_qmax = m_msh; m_per = 0; m_state = SSCAN;
        end else begin
          m_tcnt++;
          if (m_tsh != 0 && m_tcnt == m_tsh) begin m_state = SERR; m_err = 1; end
        end
      end else if (m_state == SSCAN) begin
        qs.push_back(int'(sig_in)); qp.push_back(int'(ramp_A));
        if (trigger_low) begin
          m_per++;
          if (m_per >= ((m_nsh == 0) ? 1 : m_nsh)) begin m_state = SSEEK; m_tcnt = 0; end
        end
      end else if (m_state == SSEEK) begin
        best(bv, bp);
        if (int'(ramp_A) == bp) begin m_state = SLOCK; m_done = 1; end
        else begin
          m_tcnt++;
          if (m_tsh != 0 && m_tcnt == m_tsh) begin m_state = SERR; m_err = 1; end
        end
      end
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clk) begin
    int bv, bp;
    best(bv, bp);
    chk("state", state, m_state);
    chk("ramp_enable", ramp_enable, (m_state == SARM || m_state == SSCAN ||
        (m_state == SSEEK && int'(ramp_A) != bp)));
    chk("ramp_reset", ramp_reset, m_state == SRRST);
    chk("lock_en", lock_en, m_state == SLOCK);
    chk("busy", busy, m_state >= SRRST && m_state <= SSEEK);
    chk("done", done, m_done);
    chk("error", error, m_err);
    chk("peak_val", peak_val, bv);
    chk("peak_pos", peak_pos, bp);
  end

  // ---------------- event counters for literal checks ----------------
  int scan_trigs = 0, rrst_cycles = 0, arm_cycles = 0;
  always @(negedge clk) begin
    if (state == 3'(SSCAN) && trigger_low) scan_trigs++;
    if (state == 3'(SRRST)) rrst_cycles++;
    if (state == 3'(SARM)) arm_cycles++;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_state(input int s, input int max_cycles, input string name);
    int n = 0;
    while (state != 3'(s) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk(name, state, s);
  endtask

  task automatic clear_counts();
    scan_trigs = 0; rrst_cycles = 0; arm_cycles = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset state", state, 0);
    chk("reset busy", busy, 0);
    chk("reset peak_val", peak_val, 0);

    // Max search over two periods; n_scans change after RRST must be ignored.
    mode = 0; search_max = 1'b1; n_scans = 8'd2; timeout = 32'd0;
    clear_counts();
    pulse_start();
    wait_state(SARM, 20, "reach ARM");
    n_scans = 8'd7;
    wait_state(SLOCK, 400, "t1 reach LOCK");
    chk("t1 scan triggers", scan_trigs, 2);
    chk("t1 peak_val", peak_val, 500);
    chk("t1 peak_pos", peak_pos, 120);
    chk("t1 lock_en", lock_en, 1);
    chk("t1 done", done, 1);
    chk("t1 ramp_enable", ramp_enable, 0);

    // Min search with two equal minima: earliest position wins.
    mode = 1; search_max = 1'b0; n_scans = 8'd1;
    pulse_start();
    wait_state(SLOCK, 400, "t2 reach LOCK");
    chk("t2 peak_val", peak_val, -300);
    chk("t2 peak_pos", peak_pos, -50);

    // Timeout in ARM with no trigger_low.
    no_trig = 1'b1; timeout = 32'd1000;
    clear_counts();
    pulse_start();
    wait_state(SERR, 1200, "t3 reach ERR");
    chk("t3 ARM cycles", arm_cycles, 1000);
    chk("t3 error", error, 1);
    chk("t3 ramp_enable", ramp_enable, 0);
    no_trig = 1'b0;

    // Abort during SCAN.
    mode = 0; search_max = 1'b1; n_scans = 8'd3; timeout = 32'd0;
    pulse_start();
    wait_state(SSCAN, 20, "t4 reach SCAN");
    repeat (10) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("t4 state", state, SIDLE);
    chk("t4 busy", busy, 0);
    chk("t4 ramp_enable", ramp_enable, 0);
    chk("t4 peak_val", peak_val, 0);  // best of ramp -100..0 so far
    repeat (5) @(negedge clk);

    // n_scans=0 acts as 1; start held high gives one RRST only.
    n_scans = 8'd0;
    clear_counts();
    @(posedge clk); #1 start = 1'b1;
    repeat (50) @(posedge clk);
    #1 start = 1'b0;
    wait_state(SLOCK, 400, "t5 reach LOCK");
    chk("t5 RRST cycles", rrst_cycles, 1);
    chk("t5 scan triggers", scan_trigs, 1);
    chk("t5 peak_pos", peak_pos, 120);

    // Asynchronous reset mid-SEEK.
    n_scans = 8'd1;
    pulse_start();
    wait_state(SSEEK, 100, "t6 reach SEEK");
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6 state", state, 0);
    chk("t6 ramp_enable", ramp_enable, 0);
    chk("t6 busy", busy, 0);
    chk("t6 done", done, 0);
    chk("t6 peak_val", peak_val, 0);
    chk("t6 peak_pos", peak_pos, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6 idle after reset", state, SIDLE);
    pulse_start();
    wait_state(SLOCK, 400, "t6 relock");
    chk("t6 relock peak_val", peak_val, 500);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ramp_scan_ctrl.md
RAMP_SCAN_CTRL -- requirements
Module: ramp_scan_ctrl

Interface
REQ-001 Parameter R, default 14, is the signal width of the ramp and error datapath.
REQ-002 Ports `clk` and `rst`: clk is input, 1 bit, the single clock; rst is input, 1 bit, the asynchronous active-high reset.
REQ-003 Port `start`: input, 1 bit; a rising edge launches a scan sequence.
REQ-004 Port `abort`: input, 1 bit; level-sensitive, returns the block to IDLE.
REQ-005 Port `n_scans`: input, 8 bits; number of full ramp periods to search (0 is treated as 1).
REQ-006 Port `timeout`: input, 32 bits; maximum clk cycles allowed in ARM or SEEK (0 = no timeout).
REQ-007 Port `search_max`: input, 1 bit; 1 = find the maximum of sig_in, 0 = find the minimum.
REQ-008 Port `ramp_A`: input, signed R bits; current ramp value from the ramp generator.
REQ-009 Ports `trigger_low` and `trigger_hig`: input, 1 bit each; one-cycle ramp limit pulses from the ramp generator.
REQ-010 Port `sig_in`: input, signed R bits; error/transmission signal to be searched.
REQ-011 Ports `ramp_enable` and `ramp_reset`: output, 1 bit each; ramp generator controls.
REQ-012 Ports `peak_val` and `peak_pos`: output, signed R bits each; the found extremum and the ramp_A value at which it occurred.
REQ-013 Port `lock_en`: output, 1 bit; hands control to the PID loops.
REQ-014 Ports `busy`, `done` and `error`: output, 1 bit each; status flags.
REQ-015 Port `state`: output, 3 bits; current FSM state encoding.

Function
REQ-016 The FSM states SHALL be IDLE=0, RRST=1, ARM=2, SCAN=3, SEEK=4, LOCK=5, ERR=6.
REQ-017 IDLE: on a start rising edge, the FSM goes to RRST; all outputs are low except done and error, which hold their values.
REQ-018 RRST: ramp_reset=1 for exactly one cycle; next state is ARM; done and error are cleared.
REQ-019 ARM: ramp_enable=1; on trigger_low the FSM goes to SCAN and loads the extremum tracker with sig_in and ramp_A from that same cycle.
REQ-020 SCAN: ramp_enable=1; each cycle, if sig_in is strictly greater (search_max=1) or strictly less (search_max=0) than peak_val, then peak_val and peak_pos update on the next edge; ties keep the earliest position.
REQ-021 SCAN: each trigger_low increments the period counter; when the count reaches max(n_scans,1), the FSM goes to SEEK with the tracker frozen; a simultaneous better sample on that trigger cycle is still captured.
REQ-022 SEEK: ramp_enable=1 until ramp_A==peak_pos is seen; in that cycle ramp_enable drops combinationally to 0 and the next state is LOCK.
REQ-023 LOCK: ramp_enable=0, lock_en=1, done=1; the FSM stays in LOCK until abort or a new start edge (start edge goes to RRST).
REQ-024 Timeout: a 32-bit cycle counter clears on entry to ARM and to SEEK; when it reaches a nonzero timeout value, the FSM goes to ERR.
REQ-025 ERR: error=1, all ramp and lock outputs are 0; the FSM leaves ERR only via abort (to IDLE) or a start edge (to RRST).
REQ-026 Abort SHALL take priority over all transitions: the next state is IDLE, ramp_enable=0 and lock_en=0 on the following cycle; peak_val and peak_pos hold.
REQ-027 busy=1 in RRST, ARM, SCAN and SEEK only.
REQ-028 Start edge detection SHALL use a registered copy of start; a start held high does not retrigger.
REQ-029 n_scans, timeout and search_max are sampled into shadow registers in RRST; changes during a sequence are ignored.
REQ-030 trigger_hig is unused for sequencing; it SHALL NOT affect state.

Reset
REQ-031 On rst asserted, the FSM SHALL go to IDLE and all outputs, counters, shadow registers, peak_val and peak_pos SHALL be 0, asynchronously.
REQ-032 Reset deasserted mid-sequence restarts only on a fresh start edge.

Structure
REQ-033 State encodings and the R default SHALL reside in the shared lock package.
REQ-034 The extremum tracker (compare, capture value and position, freeze) SHALL be one sub-module named peak_tracker.

Verification
REQ-035 start pulse, n_scans=2, search_max=1, sig_in peak 500 at ramp_A=120 -> after 2 trigger_low pulses, SEEK; ramp_enable falls when ramp_A=120; lock_en=1, peak_val=500, peak_pos=120.
REQ-036 search_max=0, two equal minima (-300 at ramp_A=-50 and at ramp_A=80) -> peak_pos=-50.
REQ-037 timeout=1000, no trigger_low -> ERR at cycle 1000 of ARM, error=1, ramp_enable=0.
REQ-038 abort asserted during SCAN -> state=IDLE, busy=0, ramp_enable=0 next cycle, peak registers hold.
REQ-039 n_scans=0 -> behaves as 1 scan; start held high for 50 cycles -> exactly one RRST.
REQ-040 rst asserted mid-SEEK without a clock edge -> all outputs 0 immediately.
